// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared types and constants for the ALU op sequencer
package alu_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int FUNC_W        = 3;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DECODE = 2'd1,
        S_EXEC   = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    localparam logic [FUNC_W-1:0] F_000 = 3'b000;
    localparam logic [FUNC_W-1:0] F_001 = 3'b001;
    localparam logic [FUNC_W-1:0] F_010 = 3'b010;
    localparam logic [FUNC_W-1:0] F_011 = 3'b011;
    localparam logic [FUNC_W-1:0] F_100 = 3'b100;
    localparam logic [FUNC_W-1:0] F_101 = 3'b101;
    localparam logic [FUNC_W-1:0] F_110 = 3'b110;
    localparam logic [FUNC_W-1:0] F_111 = 3'b111;

    // Packed command word: {func, a, b}
    function automatic int cmd_width(input int width);
        return FUNC_W + 2 * width;
    endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// rtl/alu_cmd_fifo.sv - command FIFO with wrap-bit pointers, no full-pop bypass
module alu_cmd_fifo #(
    parameter int DEPTH = 2,
    parameter int DW    = 19
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic          full,
    output logic          empty,
    output logic [DW-1:0] head_data
);

    localparam int          AW      = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    logic [DW-1:0] mem_q [DEPTH];
    logic          push_ok;
    logic          pop_ok;

    // Full/empty come only from registered pointers, so a pop never frees a slot in the same cycle
    assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty     = (wr_ptr_q == rd_ptr_q);
    assign push_ok   = push && !full;
    assign pop_ok    = pop && !empty;
    assign head_data = mem_q[rd_ptr_q[AW-1:0]];

    // Pointer advance; the extra wrap bit distinguishes full from empty
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    end

    // Pointer registers; reset empties the FIFO
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage write; contents need no reset since the pointers gate visibility
    always_ff @(posedge clk) begin
        if (push_ok && !rst) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - queues ALU commands, drives function select, returns results
module alu_op_sequencer
    import alu_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_func,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    output logic             f2,
    output logic             f1,
    output logic             f0,
    input  logic             fBit,
    output logic             alu_en,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_result,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic [2:0]       res_func,
    output logic             busy
);

    localparam int CMD_W = cmd_width(WIDTH);

    state_t           state_q, state_d;
    logic [2:0]       op_func_q, op_func_d;
    logic [WIDTH-1:0] op_a_q, op_a_d;
    logic [WIDTH-1:0] op_b_q, op_b_d;
    logic             long_op_q, long_op_d;
    logic             second_q, second_d;
    logic [WIDTH-1:0] res_data_q, res_data_d;
    logic [2:0]       res_func_q, res_func_d;

    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_push;
    logic             fifo_pop;
    logic [CMD_W-1:0] head_data;
    logic [2:0]       head_func;
    logic [WIDTH-1:0] head_a;
    logic [WIDTH-1:0] head_b;
    logic             fsel_active;

    assign cmd_ready = !fifo_full && !rst;
    assign fifo_push = cmd_valid && cmd_ready;
    assign {head_func, head_a, head_b} = head_data;

    alu_cmd_fifo #(
        .DEPTH (DEPTH),
        .DW    (CMD_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data ({cmd_func, cmd_a, cmd_b}),
        .pop       (fifo_pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head_data (head_data)
    );

    // Next-state logic: pop in IDLE, sample fBit in DECODE, one or two EXEC cycles, hold in DONE
    always_comb begin
        state_d    = state_q;
        op_func_d  = op_func_q;
        op_a_d     = op_a_q;
        op_b_d     = op_b_q;
        long_op_d  = long_op_q;
        second_d   = second_q;
        res_data_d = res_data_q;
        res_func_d = res_func_q;
        fifo_pop   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop  = 1'b1;
                    op_func_d = head_func;
                    op_a_d    = head_a;
                    op_b_d    = head_b;
                    state_d   = S_DECODE;
                end
            end
            S_DECODE: begin
                long_op_d = fBit;
                second_d  = 1'b0;
                state_d   = S_EXEC;
            end
            S_EXEC: begin
                if (long_op_q && !second_q) begin
                    second_d = 1'b1;
                end else begin
                    res_data_d = alu_result;
                    res_func_d = op_func_q;
                    state_d    = S_DONE;
                end
            end
            S_DONE: begin
                if (res_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, op and result registers; reset drops any in-flight op
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            op_func_q  <= F_000;
            op_a_q     <= '0;
            op_b_q     <= '0;
            long_op_q  <= 1'b0;
            second_q   <= 1'b0;
            res_data_q <= '0;
            res_func_q <= F_000;
        end else begin
            state_q    <= state_d;
            op_func_q  <= op_func_d;
            op_a_q     <= op_a_d;
            op_b_q     <= op_b_d;
            long_op_q  <= long_op_d;
            second_q   <= second_d;
            res_data_q <= res_data_d;
            res_func_q <= res_func_d;
        end
    end

    // Function select is live from DECODE through EXEC and parked at zero otherwise
    assign fsel_active  = (state_q == S_DECODE) || (state_q == S_EXEC);
    assign {f2, f1, f0} = fsel_active ? op_func_q : F_000;
    assign alu_en       = (state_q == S_EXEC);
    assign alu_a        = op_a_q;
    assign alu_b        = op_b_q;
    assign res_valid    = (state_q == S_DONE);
    assign res_data     = res_data_q;
    assign res_func     = res_func_q;
    assign busy         = (state_q != S_IDLE) || !fifo_empty;

endmodule
